uart_baud_gen: RTL

Parametrised baud-rate generator for the UART, successor to the fixed 16-bit, ×8 clock generator. It holds a programmable integer divisor with a 4-bit fractional part and a programmable oversampling ratio, updated atomically through a shadow register. It drives two independent dividers: a TX chain producing a bit-rate strobe, and an RX chain producing an oversample strobe and a bit-centre strobe. The RX chain can be re-phased on a start-bit edge. It sits between the CPU register bus and the UART TX/RX shifters.

---
 rtl/uart_baud_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable fractional baud-rate generator.
// The TX chain yields one strobe per bit. The RX chain yields oversample
// and bit-centre strobes, and can be re-phased on a start-bit edge.
// Configuration is staged byte-wise and becomes active atomically on a
// write to the CFG byte.

module uart_baud_gen #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_RST = 1,
  parameter int unsigned OVS_RST = 7,
  localparam int unsigned ADDR_W = $clog2(DIV_W / 8 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rx_resync,
  output logic              rx_tick,
  output logic              rx_mid,
  output logic              tx_tick
);

  localparam int unsigned NBYTES = DIV_W / 8;
  // One spare bit so that an all-ones divisor plus the fractional
  // extension is still reachable without wrapping.
  localparam int unsigned CNT_W  = DIV_W + 1;

  logic [DIV_W-1:0] stage_div;
  logic [DIV_W-1:0] act_div;
  logic [3:0]       frac;
  logic [3:0]       ovs;

  logic [CNT_W-1:0] tx_c;
  logic [3:0]       tx_acc;
  logic             tx_ext;
  logic [3:0]       o_tx;

  logic [CNT_W-1:0] rx_c;
  logic [3:0]       rx_acc;
  logic             rx_ext;
  logic [3:0]       o_rx;

  logic             commit;
  logic [CNT_W-1:0] tx_term;
  logic [CNT_W-1:0] rx_term;
  logic             tx_div_stb;
  logic             rx_div_stb;
  logic [4:0]       tx_sum;
  logic [4:0]       rx_sum;

  assign commit = wr_en && (wr_addr == ADDR_W'(NBYTES));

  // Divider terminals and strobe decodes; reset also masks the strobes
  // so they fall immediately for any DIV_RST.
  assign tx_term    = {1'b0, act_div} + CNT_W'(tx_ext);
  assign rx_term    = {1'b0, act_div} + CNT_W'(rx_ext);
  assign tx_div_stb = en && !rst && (tx_c == tx_term);
  assign rx_div_stb = en && !rst && (rx_c == rx_term);
  assign tx_sum     = 5'(tx_acc) + 5'(frac);
  assign rx_sum     = 5'(rx_acc) + 5'(frac);

  assign tx_tick = tx_div_stb && (o_tx == ovs);
  assign rx_tick = rx_div_stb && !rx_resync;
  assign rx_mid  = rx_tick && (o_rx == (ovs >> 1));

  // Staging divisor bytes and the active configuration loaded on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_div <= DIV_W'(DIV_RST);
      act_div   <= DIV_W'(DIV_RST);
      frac      <= 4'd0;
      ovs       <= 4'(OVS_RST);
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          stage_div[i*8 +: 8] <= wr_data;
        end
      end
      if (commit) begin
        act_div <= stage_div;
        frac    <= wr_data[7:4];
        ovs     <= wr_data[3:0];
      end
    end
  end

  // TX chain: fractional divider followed by the bit-rate counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_c   <= '0;
      tx_acc <= 4'd0;
      tx_ext <= 1'b0;
      o_tx   <= 4'd0;
    end else if (!en || commit) begin
      tx_c   <= '0;
      tx_acc <= 4'd0;
      tx_ext <= 1'b0;
      o_tx   <= 4'd0;
    end else if (tx_div_stb) begin
      tx_c             <= '0;
      {tx_ext, tx_acc} <= tx_sum;
      o_tx             <= (o_tx == ovs) ? 4'd0 : o_tx + 4'd1;
    end else begin
      tx_c <= tx_c + CNT_W'(1);
    end
  end

  // RX chain: fractional divider plus oversample phase, re-phased on resync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_c   <= '0;
      rx_acc <= 4'd0;
      rx_ext <= 1'b0;
      o_rx   <= 4'd0;
    end else if (!en || commit || rx_resync) begin
      rx_c   <= '0;
      rx_acc <= 4'd0;
      rx_ext <= 1'b0;
      o_rx   <= 4'd0;
    end else if (rx_div_stb) begin
      rx_c             <= '0;
      {rx_ext, rx_acc} <= rx_sum;
      o_rx             <= (o_rx == ovs) ? 4'd0 : o_rx + 4'd1;
    end else begin
      rx_c <= rx_c + CNT_W'(1);
    end
  end

endmodule
